// File: rtl/zap_mem_arbiter.sv
// Arbitrates one registered RAM port between the core's data (D) and
// instruction-fetch (I) ports. D has priority; a starvation guard lets I through.
module zap_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_data,
    input  logic        i_d_ren,
    input  logic        i_d_wen,
    input  logic [3:0]  i_d_ben,
    input  logic        i_d_flush,
    output logic [31:0] o_d_data,
    output logic        o_d_stall,
    input  logic [31:0] i_i_address,
    input  logic        i_i_ren,
    input  logic        i_i_flush,
    output logic [31:0] o_i_data,
    output logic        o_i_stall,
    output logic [31:0] o_ram_addr,
    output logic        o_ram_rd_en,
    output logic        o_ram_wr_en,
    output logic [3:0]  o_ram_ben,
    output logic [31:0] o_ram_data,
    input  logic [31:0] i_ram_data,
    input  logic        i_ram_stall,
    output logic        o_owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve;
    logic       req_d;
    logic       req_i;
    logic       grant_d;
    logic       grant_i;
    logic       done;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    assign req_d = (i_d_ren | i_d_wen) & ~i_d_flush;
    assign req_i = i_i_ren & ~i_i_flush;

    // Read data is broadcast; only the owner's completion cycle is meaningful.
    assign o_d_data = i_ram_data;
    assign o_i_data = i_ram_data;

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        done      = 1'b0;
        o_d_stall = i_d_ren | i_d_wen;
        o_i_stall = i_i_ren;
        case (state)
            IDLE: begin
                if (req_d && !(req_i && starve == LIMIT)) begin
                    grant_d = 1'b1;
                end else if (req_i) begin
                    grant_i = 1'b1;
                end
                if (grant_d || grant_i) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // The non-owner keeps its raw-request stall from the defaults.
                done = ~i_ram_stall;
                if (o_owner) begin
                    o_i_stall = i_ram_stall;
                end else begin
                    o_d_stall = i_ram_stall;
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant stage: capture the winner into the registered RAM port
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ram_addr  <= 32'd0;
            o_ram_data  <= 32'd0;
            o_ram_ben   <= 4'd0;
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
            o_owner     <= 1'b0;
        end else if (grant_d) begin
            o_ram_addr  <= i_d_address;
            o_ram_data  <= i_d_data;
            o_ram_ben   <= i_d_ben;
            o_ram_rd_en <= i_d_ren;
            o_ram_wr_en <= i_d_wen;
            o_owner     <= 1'b0;
        end else if (grant_i) begin
            o_ram_addr  <= i_i_address;
            o_ram_data  <= 32'd0;
            o_ram_ben   <= 4'hF;
            o_ram_rd_en <= 1'b1;
            o_ram_wr_en <= 1'b0;
            o_owner     <= 1'b1;
        end else if (done) begin
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
        end
    end

    // Counts D grants that overtook a waiting I request
    always_ff @(posedge i_clk) begin
        if (i_reset || !req_i || grant_i) begin
            starve <= 4'd0;
        end else if (grant_d) begin
            starve <= sat_inc(starve);
        end
    end

endmodule
